elink_2bit_frame_tx: RTL and testbench

//  Host-side e-link downlink transmitter: accepts one 76-bit MOPSHUB downlink message
//  ({bus_id, CAN frame}) per handshake, frames it (SOP/payload/EOP, byte-stuffed) and

---
 rtl/elink_pkg.sv | 41 ++++
 rtl/elink_2bit_serializer.sv | 33 +++
 rtl/elink_2bit_frame_tx.sv | 170 +++++++++++++++++
 tb/tb_elink_2bit_frame_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elink_pkg.sv
// Shared codes, sizes, state type and byte helpers for the 2-bit e-link frame transmitter.
// ELINK_TX_CRC8_EN adds the ST_CRC state used when a CRC-8 trailer byte is framed.
package elink_pkg;

   localparam logic [7:0] IDLE_CODE = 8'hBC;
   localparam logic [7:0] SOP_CODE  = 8'h3C;
   localparam logic [7:0] EOP_CODE  = 8'hDC;
   localparam logic [7:0] ESC_CODE  = 8'h7D;
   localparam logic [7:0] ESC_XOR   = 8'h20;

   localparam int MSG_BITS      = 76;
   localparam int PAYLOAD_BYTES = (MSG_BITS + 7) / 8;

   // The state names the byte currently on the wire.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SOP  = 3'd1,
      ST_DATA = 3'd2,
      ST_ESC  = 3'd3,
`ifdef ELINK_TX_CRC8_EN
      ST_CRC  = 3'd4,
`endif
      ST_EOP  = 3'd5
   } tx_state_t;

   // CRC-8, polynomial 0x07, MSB first, one byte per call.
   function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   function automatic logic is_kcode(input logic [7:0] data);
      return (data == IDLE_CODE) || (data == SOP_CODE) ||
             (data == EOP_CODE)  || (data == ESC_CODE);
   endfunction

endpackage

// File: rtl/elink_2bit_serializer.sv
// Byte-to-2-bit serializer: a free-running phase counter shifts the current byte out MSB pair
// first and loads load_byte on the last phase, so it appears on the very next cycle.
module elink_2bit_serializer
   import elink_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] load_byte,
   output logic [1:0] tx_elink2bit,
   output logic       byte_last
);

   logic [1:0] phase_reg;
   logic [7:0] shift_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_reg <= 2'd0;
         shift_reg <= IDLE_CODE;
      end else begin
         phase_reg <= phase_reg + 2'd1;
         if (phase_reg == 2'd3) begin
            shift_reg <= load_byte;
         end else begin
            shift_reg <= {shift_reg[5:0], 2'b00};
         end
      end
   end

   assign tx_elink2bit = shift_reg[7:6];
   assign byte_last    = (phase_reg == 2'd3);

endmodule

// File: rtl/elink_2bit_frame_tx.sv
// E-link downlink transmitter: captures one message, frames it as SOP/payload/EOP with byte
// stuffing and streams IDLE in between. ELINK_TX_CRC8_EN appends a stuffed CRC-8 before EOP.
module elink_2bit_frame_tx
   import elink_pkg::*;
#(
   parameter int MSG_W = 76,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             msg_valid,
   output logic             msg_ready,
   input  logic [MSG_W-1:0] msg_data,
   output logic [1:0]       tx_elink2bit,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int NBYTES = (MSG_W + 7) / 8;
   localparam int PAD_W  = NBYTES * 8;
`ifdef ELINK_TX_CRC8_EN
   localparam int NSTUFF = NBYTES + 1;
`else
   localparam int NSTUFF = NBYTES;
`endif
   localparam int IDX_W = $clog2(NSTUFF + 1);
   localparam logic [IDX_W-1:0] PAY_END  = IDX_W'(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTUFF);

   tx_state_t        state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic [MSG_W-1:0] msg_reg;
   logic [CNT_W-1:0] frame_cnt_reg;
   logic [PAD_W-1:0] padded;
   logic [7:0]       pay_bytes [NBYTES];
   logic [7:0]       cur_byte;
   logic [7:0]       load_byte;
   logic             byte_last;
   logic             capture;
   logic             commit;

   // Payload byte 0 carries the zero-padded top bits of the message.
   assign padded = PAD_W'(msg_reg);

   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_pay
         assign pay_bytes[gi] = padded[PAD_W-1-8*gi -: 8];
      end
   endgenerate

`ifdef ELINK_TX_CRC8_EN
   logic [7:0] crc_reg, crc_next;
   logic       is_crc_slot;

   assign is_crc_slot = (idx_reg == PAY_END);

   always_comb begin
      crc_next = crc_reg;
      if (capture) begin
         crc_next = 8'h00;
      end else if (commit && !is_crc_slot) begin
         crc_next = crc8_upd(crc_reg, cur_byte);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_reg <= 8'h00;
      end else begin
         crc_reg <= crc_next;
      end
   end
`endif

   // Unstuffed value of the next payload (or CRC) slot.
   always_comb begin
      cur_byte = 8'h00;
      if (idx_reg < PAY_END) begin
         cur_byte = pay_bytes[idx_reg];
      end
`ifdef ELINK_TX_CRC8_EN
      else begin
         cur_byte = crc_reg;
      end
`endif
   end

   // Decisions are made on the last phase of the byte on the wire; the chosen byte is loaded then.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      load_byte  = IDLE_CODE;
      capture    = 1'b0;
      commit     = 1'b0;
      if (byte_last) begin
         case (state_reg)
            ST_IDLE: begin
               if (msg_valid) begin
                  load_byte  = SOP_CODE;
                  state_next = ST_SOP;
                  idx_next   = '0;
                  capture    = 1'b1;
               end
            end
            ST_ESC: begin
               load_byte = cur_byte ^ ESC_XOR;
               commit    = 1'b1;
            end
            ST_EOP: begin
               load_byte  = IDLE_CODE;
               state_next = ST_IDLE;
            end
            default: begin
               if (idx_reg == LAST_IDX) begin
                  load_byte  = EOP_CODE;
                  state_next = ST_EOP;
               end else if (is_kcode(cur_byte)) begin
                  load_byte  = ESC_CODE;
                  state_next = ST_ESC;
               end else begin
                  load_byte = cur_byte;
                  commit    = 1'b1;
               end
            end
         endcase
         if (commit) begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_DATA;
`ifdef ELINK_TX_CRC8_EN
            if (is_crc_slot) begin
               state_next = ST_CRC;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= '0;
         msg_reg       <= '0;
         frame_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         if (capture) begin
            msg_reg <= msg_data;
         end
         if (frame_done) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
         end
      end
   end

   assign msg_ready  = (state_reg == ST_IDLE) && byte_last;
   assign busy       = (state_reg != ST_IDLE);
   assign frame_done = (state_reg == ST_EOP) && byte_last;
   assign frame_cnt  = frame_cnt_reg;

   elink_2bit_serializer u_ser (
      .clk          (clk),
      .rst          (rst),
      .load_byte    (load_byte),
      .tx_elink2bit (tx_elink2bit),
      .byte_last    (byte_last)
   );

endmodule

// File: tb/tb_elink_2bit_frame_tx.sv
// Scoreboard bench for elink_2bit_frame_tx: stimulus pushes model frames, a monitor decodes the
// 2-bit stream into bytes and compares frames, control strobes, spacing and counters.
module tb_elink_2bit_frame_tx;

   localparam logic [7:0] IDLE_B = 8'hBC;
   localparam logic [7:0] SOP_B  = 8'h3C;
   localparam logic [7:0] EOP_B  = 8'hDC;
   localparam logic [7:0] ESC_B  = 8'h7D;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        msg_valid = 1'b0;
   logic [75:0] msg_data = '0;
   logic        msg_ready;
   logic [1:0]  tx_elink2bit;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   elink_2bit_frame_tx #(.MSG_W(76), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .msg_valid    (msg_valid),
      .msg_ready    (msg_ready),
      .msg_data     (msg_data),
      .tx_elink2bit (tx_elink2bit),
      .busy         (busy),
      .frame_done   (frame_done),
      .frame_cnt    (frame_cnt)
   );

   int chk_cnt = 0;
   int pass_cnt = 0;
   logic [7:0] byte_q[$];
   int         len_q[$];
   bit         check_gap = 1'b0;

   function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
   endfunction

   // ---------------- reference model ----------------
   function automatic int push_stuffed(input logic [7:0] b);
      if (b == IDLE_B || b == SOP_B || b == EOP_B || b == ESC_B) begin
         byte_q.push_back(ESC_B);
         byte_q.push_back(b ^ 8'h20);
         return 2;
      end
      byte_q.push_back(b);
      return 1;
   endfunction

   function automatic void push_expected(input logic [75:0] m);
      logic [79:0] p;
      int n;
      p = {4'b0000, m};
      byte_q.push_back(SOP_B);
      n = 1;
      for (int k = 0; k < 10; k++) n += push_stuffed(p[79-8*k -: 8]);
`ifdef ELINK_TX_CRC8_EN
      begin
         logic [7:0] crc;
         crc = 8'h00;
         for (int i = 79; i >= 0; i--)
            crc = {crc[6:0], 1'b0} ^ (((crc[7] ^ p[i]) != 1'b0) ? 8'h07 : 8'h00);
         n += push_stuffed(crc);
      end
`endif
      byte_q.push_back(EOP_B);
      n++;
      len_q.push_back(n);
   endfunction

   function automatic logic [75:0] make_msg();
      logic [79:0] p;
      logic [7:0]  k [4];
      k = '{8'hBC, 8'h3C, 8'hDC, 8'h7D};
      p[79:64] = 16'($urandom);
      p[63:32] = $urandom;
      p[31:0]  = $urandom;
      p[79:76] = 4'h0;
      for (int b = 1; b < 10; b++)
         if ($urandom_range(0, 3) == 0) p[79-8*b -: 8] = k[$urandom_range(0, 3)];
      return p[75:0];
   endfunction

   // ---------------- monitor ----------------
   int         cyc = 0;
   int         mphase = 0;
   int         mframes = 0;
   logic [7:0] cur = 8'h00;
   bit [3:0]   rdy_v, done_v, busy_v;
   bit         collecting = 1'b0;
   bit         after_rst = 1'b1;
   bit         have_eop = 1'b0;
   bit         xfer_pend = 1'b0;
   int         xfer_cyc = 0;
   int         sop_start = 0;
   int         eop_end = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   function automatic void compare_frame();
      int len;
      int bi;
      check("frame_pending", 64'(len_q.size() > 0), 64'd1);
      if (len_q.size() == 0) return;
      len = len_q.pop_front();
      exp_q.delete();
      for (int i = 0; i < len; i++) if (byte_q.size() > 0) exp_q.push_back(byte_q.pop_front());
      check("frame_len", 64'(got_q.size()), 64'(len));
      bi = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin bi = i; break; end
      if (got_q.size() > 0 && exp_q.size() > 0)
         check($sformatf("frame_byte[%0d]", bi), 64'(got_q[bi]), 64'(exp_q[bi]));
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            mphase = 0; collecting = 0; mframes = 0; after_rst = 1;
            have_eop = 0; xfer_pend = 0;
            byte_q.delete(); len_q.delete();
            continue;
         end
         if (msg_valid && msg_ready) begin xfer_pend = 1; xfer_cyc = cyc; end
         if (after_rst) begin
            check("reset_state", 64'({tx_elink2bit, msg_ready, busy, frame_done, frame_cnt}),
                  64'({2'b10, 3'b000, 16'h0000}));
            after_rst = 0;
         end
         cur = {cur[5:0], tx_elink2bit};
         rdy_v[mphase]  = msg_ready;
         done_v[mphase] = frame_done;
         busy_v[mphase] = busy;
         if (mphase == 3) begin
            check("ctrl", 64'({rdy_v, done_v, busy_v}),
                  64'({(cur == IDLE_B) ? 4'b1000 : 4'b0000,
                       (cur == EOP_B)  ? 4'b1000 : 4'b0000,
                       (cur == IDLE_B) ? 4'b0000 : 4'b1111}));
            check("frame_cnt", 64'(frame_cnt), 64'(mframes[15:0]));
            if (!collecting) begin
               if (cur == SOP_B) begin
                  collecting = 1;
                  got_q.delete();
                  got_q.push_back(cur);
                  sop_start = cyc - 3;
                  check("sop_latency", xfer_pend ? 64'(sop_start - xfer_cyc) : 64'hFFFF, 64'd1);
                  xfer_pend = 0;
                  if (have_eop) begin
                     if (check_gap) check("gap_exact", 64'(sop_start - eop_end), 64'd5);
                     else check("gap_min", 64'((sop_start - eop_end) >= 5), 64'd1);
                  end
               end else begin
                  check("idle_byte", 64'(cur), 64'(IDLE_B));
               end
            end else begin
               got_q.push_back(cur);
               if (cur == EOP_B) begin
                  collecting = 0;
                  have_eop = 1;
                  eop_end = cyc;
                  compare_frame();
                  $display("frame %0d: %0d bytes, %0d cycles", mframes, got_q.size(), eop_end - sop_start + 1);
                  mframes++;
               end else if (got_q.size() > 40) begin
                  check("frame_runaway", 64'(got_q.size()), 64'd40);
                  collecting = 0;
               end
            end
         end
         mphase = (mphase + 1) & 3;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [75:0] m, input bit keep_valid);
      int t;
      t = 0;
      msg_data  = m;
      msg_valid = 1'b1;
      while (!msg_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (!msg_ready) begin
         check("ready_timeout", 64'(t), 64'd199);
         msg_valid = 1'b0;
         return;
      end
      push_expected(m);
      @(posedge clk); #1;
      msg_data[31:0] = $urandom;
      if (!keep_valid) msg_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((len_q.size() != 0 || collecting || busy) && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain", 64'(t < 400), 64'd1);
   endtask

   initial begin
      logic [75:0] r1, r2;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (16) @(posedge clk);
      #1;

      send(76'hA_0102_0304_0506_0708_09, 1'b0);
      wait_idle();

      send(76'h0_0102_BC04_0506_7D08_09, 1'b0);
      wait_idle();

      r1 = make_msg();
      r2 = make_msg();
      send(r1, 1'b1);
      msg_data = r2;
      repeat (8) @(posedge clk);
      #1 check_gap = 1'b1;
      send(r2, 1'b0);
      wait_idle();
      check_gap = 1'b0;

      send(76'h5_1122_3344_5566_7788_99, 1'b0);
      repeat (25) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      send(make_msg(), 1'b0);
      wait_idle();

      for (int i = 0; i < 15; i++) begin
         repeat ($urandom_range(0, 6)) @(posedge clk);
         #1;
         send(make_msg(), 1'b0);
      end
      wait_idle();

`ifdef ELINK_TX_CRC8_EN
      send(76'h0, 1'b0);
      send(76'h1, 1'b0);
      wait_idle();
`endif

      repeat (8) @(posedge clk);
      #1;
      check("queue_empty", 64'(len_q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
